// File: rtl/df_divider_c3.sv
// Sequential divide-by-27 of an 8-bit sample pre-shifted by 8 bits.
// Restoring division, one quotient bit per clock, with valid/ready on both sides.
module df_divider_c3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [4:0] out_rem,
  output logic       out_sat
);
  localparam logic [5:0] DIVISOR = 6'd27;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] dvd_q;
  logic [4:0]  rem_q;
  logic [11:0] quo_q;
  logic [3:0]  cnt_q;
  logic [7:0]  data_q;
  logic [4:0]  orem_q;
  logic        sat_q;

  logic [5:0]  trial;
  logic [5:0]  diff;
  logic        ge;
  logic [4:0]  rem_d;
  logic [11:0] quo_d;
  logic        sat_d;

  // One restoring step on the current working remainder.
  always_comb begin
    trial = {rem_q, dvd_q[15]};
    ge    = (trial >= DIVISOR);
    diff  = trial - DIVISOR;
    rem_d = ge ? diff[4:0] : trial[4:0];
    quo_d = {quo_q[10:0], ge};
    sat_d = (quo_d > 12'd255);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (cnt_q == 4'd15) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      orem_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          dvd_q <= {in_data, 8'b0};
          rem_q <= '0;
          quo_q <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          dvd_q <= {dvd_q[14:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 4'd1;
          // Last iteration: publish from the freshly computed step.
          if (cnt_q == 4'd15) begin
            data_q <= sat_d ? 8'hFF : quo_d[7:0];
            orem_q <= rem_d;
            sat_q  <= sat_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_rem   = orem_q;
  assign out_sat   = sat_q;
endmodule

// File: doc/df_divider_c3.md
# df_divider_c3

Sequential constant divider that inverts the fixed ×27/256 coefficient scaling on the filter datapath. It accepts an 8-bit scaled sample and returns floor(data·256/27), saturated to 8 bits, plus the remainder. It uses one restoring-division iteration per clock. The block sits on the reconstruction side of the digital filter macro and uses valid/ready handshakes on both ends.

## Interface
- No parameters; the divisor is fixed at 27 (5'd27) and the pre-shift is fixed at 8 bits.
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a sample (high only in IDLE)
- in_data  input  8  scaled sample to divide
- out_valid  output  1  result registers hold a new result
- out_ready  input  1  downstream accepts the result
- out_data  output  8  saturated quotient, min(floor(in_data·256/27), 255)
- out_rem  output  5  remainder of in_data·256 mod 27, range 0..26
- out_sat  output  1  quotient exceeded 255 (out_data forced to 255)

## Operation
- Dividend D = {in_data, 8'b0} (16 bits). The working remainder R is 5 bits and the quotient Q is 12 bits; 65535/27 = 2427 fits in 12 bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch D, clear R and Q, load iteration counter = 0, go to RUN.
- RUN: one iteration per clock, MSB of D first.
  - T = {R, D[15]} (6 bits), then D <<= 1.
  - If T ≥ 27: R = T − 27 and shift 1 into Q.
  - Otherwise: R = T[4:0] and shift 0 into Q.
  - After iteration 16 (counter wrap 15→0), load the output registers and go to DONE:
    - out_data = (Q > 255) ? 255 : Q[7:0]
    - out_sat = (Q > 255)
    - out_rem = R
- DONE:
  - out_valid = 1; out_data, out_rem and out_sat are held stable.
  - On out_ready, go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid in those states is ignored and not queued.
- Changes to in_data after acceptance have no effect.
- out_data, out_rem and out_sat keep their last values after the handshake until the next result is loaded.
- out_valid and in_ready decode directly from the state register, with no combinational path from inputs.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, counter = 0, D/R/Q = 0.
  - out_data = 0, out_rem = 0, out_sat = 0, out_valid = 0.
  - in_ready = 1 once state is IDLE; no transfer occurs while rst_n is low.
- Latency: input handshake at edge E; iterations run at edges E+1..E+16; out_valid is high from edge E+16.
- A result consumed on its first valid cycle (edge E+17) returns the block to IDLE.
- Minimum sample period is 18 cycles.
- If out_ready is already high when out_valid rises, the handshake completes at the next edge.
- Backpressure: DONE persists indefinitely while out_ready = 0, with outputs stable.
- Reset asserted in RUN or DONE aborts the operation: no out_valid pulse, and outputs clear to 0 at once.

## Test plan
- Reset, then in_data=26 with out_ready=1:
  - out_valid rises exactly 16 cycles after the accept edge.
  - out_data=246, out_rem=14, out_sat=0.
- in_data=1 → out_data=9, out_rem=13, out_sat=0. Then in_data=0 → out_data=0, out_rem=0, out_sat=0.
- Saturation, in_data=27 → out_data=255, out_rem=0, out_sat=1 (Q=256). Then in_data=255 → out_data=255, out_rem=21, out_sat=1 (Q=2417).
- Handshake stress:
  - Hold out_ready=0 for 10 cycles in DONE: outputs stay stable and in_ready stays 0.
  - Toggle in_valid with in_data=200 during RUN: it is ignored.
  - Back-to-back samples with out_ready=1 complete every 18 cycles.
- Reset asserted at iteration 7 of in_data=26:
  - out_valid never pulses and outputs read 0.
  - After release, in_data=26 again yields 246/14.
- Sweep in_data 0..255, compare against the floor(x·256/27) saturating model, and confirm latency is constant.
